// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// State and owner encodings plus watchdog width helper.
package ysyx_23060201_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Counter width able to hold limit-1.
  function automatic int wdog_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060201_mem_arbiter_rr_pick.sv
// Two-way grant between IFU and LSU.
// Ties go to LSU, or alternate when LSU_PRIO is 0.
module ysyx_23060201_rr_pick
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter int LSU_PRIO = 1
) (
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_owner,
  output logic   grant_ifu,
  output logic   grant_lsu
);

  logic ifu_wins_tie;

  assign ifu_wins_tie = (LSU_PRIO == 0) && (last_owner == OWN_LSU);
  assign grant_ifu    = ifu_valid && (!lsu_valid || ifu_wins_tie);
  assign grant_lsu    = lsu_valid && !grant_ifu;

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Single memory port shared by fetch and load/store.
// One transaction in flight, watchdog, stale-response drop.
module ysyx_23060201_mem_arbiter
  import ysyx_23060201_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LSU_PRIO = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  localparam int WW = wdog_w(TIMEOUT);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);
  localparam logic WD_EN = (TIMEOUT != 0);

  state_t            state, state_nx;
  owner_t            owner, last_owner;
  logic              stale;
  logic [WW-1:0]     wdog;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              grant_ifu, grant_lsu;
  logic              accept, rsp_fire, limit;
  logic              tmo_req, tmo_wait;

  ysyx_23060201_rr_pick #(
    .LSU_PRIO(LSU_PRIO)
  ) u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .last_owner(last_owner),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  assign ifu_req_ready = (state == S_IDLE) && !stale && grant_ifu;
  assign lsu_req_ready = (state == S_IDLE) && !stale && grant_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  assign mem_req_valid = (state == S_REQ);
  assign mem_rsp_ready = (state == S_WAIT) || stale;

  assign ifu_rsp_valid = (state == S_RESP) && (owner == OWN_IFU);
  assign lsu_rsp_valid = (state == S_RESP) && (owner == OWN_LSU);
  assign ifu_rsp_rdata = (owner == OWN_IFU) ? rdata : '0;
  assign lsu_rsp_rdata = (owner == OWN_LSU) ? rdata : '0;
  assign ifu_rsp_err   = (owner == OWN_IFU) && err;
  assign lsu_rsp_err   = (owner == OWN_LSU) && err;

  assign rsp_fire = (ifu_rsp_valid && ifu_rsp_ready) ||
                    (lsu_rsp_valid && lsu_rsp_ready);
  assign limit    = WD_EN && (wdog == WLIM);
  assign tmo_req  = (state == S_REQ) && limit && !mem_req_ready;
  assign tmo_wait = (state == S_WAIT) && limit && !mem_rsp_valid;

  // Next-state decode; a handshake beats a same-cycle timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_REQ;
      S_REQ: begin
        if (mem_req_ready) state_nx = S_WAIT;
        else if (tmo_req)  state_nx = S_RESP;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_nx = S_RESP;
        else if (tmo_wait) state_nx = S_RESP;
      end
      S_RESP: if (rsp_fire) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latch the granted request and track ownership history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner         <= OWN_IFU;
      last_owner    <= OWN_LSU;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      if (accept) begin
        owner         <= grant_lsu ? OWN_LSU : OWN_IFU;
        mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
        mem_req_wen   <= grant_lsu && lsu_req_wen;
        mem_req_wdata <= grant_lsu ? lsu_req_wdata : '0;
        mem_req_wmask <= grant_lsu ? lsu_req_wmask : '0;
      end
      if (rsp_fire) last_owner <= owner;
    end
  end

  // Watchdog counts cycles spent in REQ and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog <= '0;
    else if (accept)
      wdog <= '0;
    else if (state == S_REQ || state == S_WAIT)
      wdog <= wdog + WW'(1);
  end

  // Response data: memory result, or zero with err on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (state == S_WAIT && mem_rsp_valid) begin
      rdata <= mem_req_wen ? '0 : mem_rsp_rdata;
      err   <= 1'b0;
    end else if (tmo_req || tmo_wait) begin
      rdata <= '0;
      err   <= 1'b1;
    end
  end

  // An abandoned WAIT leaves one late response to swallow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stale <= 1'b0;
    else if (tmo_wait)               stale <= 1'b1;
    else if (stale && mem_rsp_valid) stale <= 1'b0;
  end

endmodule
